char_buffer_writer: RTL and testbench
=====================================

# char_buffer_writer

Producer side of the 80x24 character buffer: accepts a byte stream of ASCII codes over a valid/ready handshake and turns it into character-buffer writes, cursor position and scroll-offset updates. Its outputs drive the video generator's buffer write port, `cursor_x`/`cursor_y` and `buffer_first_char`/`buffer_first_char_wen` inputs. It also performs the power-on screen clear and the new-line clear on scroll.

## Interface
- `ROWS`, default 24: text rows.
- `COLS`, default 80: text columns.
- `ROW_BITS`, default 5: width of `cursor_y`.
- `COL_BITS`, default 7: width of `cursor_x`.
- `ADDR_BITS`, default 11: buffer address width.
- `PAST_LAST_ROW`, default ROWS*COLS (1920): buffer size; first address past the buffer.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `char_in`  in  8  ASCII byte.
- `char_valid`  in  1  `char_in` valid.
- `char_ready`  out  1  block can accept a byte. A byte transfers on a rising edge with `char_valid & char_ready`.
- `cursor_x`  out  COL_BITS  cursor column, 0..COLS-1.
- `cursor_y`  out  ROW_BITS  cursor row, 0..ROWS-1.
- `buffer_first_char`  out  ADDR_BITS  buffer address of the top-left screen character.
- `buffer_first_char_wen`  out  1  one-cycle strobe loading `buffer_first_char`.
- `buffer_waddr`  out  ADDR_BITS  write address.
- `buffer_din`  out  8  write data.
- `buffer_wen`  out  1  write enable. Writes are one per cycle while high.

## Operation
- **Outputs:** all outputs are registered. `char_ready` = (state == IDLE).
- **Internal register `line_start`:** buffer address of the cursor row. It is always a multiple of COLS and less than PAST_LAST_ROW.
- **Write address:** `line_start + cursor_x`. This sum never reaches PAST_LAST_ROW, so no wrap is needed.
- **Row advance:** `line_start + COLS` and `buffer_first_char + COLS` wrap to 0 when the result equals PAST_LAST_ROW.
- **States:** CLEAR_ALL, IDLE, CLEAR_LINE.
- **CLEAR_ALL** (entered on reset):
  - A counter writes 0x20 to addresses 0..PAST_LAST_ROW-1, one per cycle.
  - After the last write, go to IDLE.
- **IDLE, on byte accept:**
  - **0x20..0x7E (printable):** write the byte at `line_start + cursor_x`. `cursor_x` increments unless it is already COLS-1; there is no autowrap, so later bytes overwrite the last column. Stay in IDLE, giving 1 byte/cycle throughput.
  - **0x0D (CR):** `cursor_x` <= 0.
  - **0x08 (BS):** `cursor_x` decrements if nonzero. No write.
  - **0x0A (LF), `cursor_y` < ROWS-1:** `cursor_y` increments and `line_start` advances. No write.
  - **0x0A (LF), `cursor_y` == ROWS-1:** scroll.
    - `line_start` advances and `cursor_y` is held.
    - Go to CLEAR_LINE, which writes 0x20 at new `line_start + 0 .. COLS-1`, one per cycle.
    - On the last clear write, `buffer_first_char` advances (wrapped), `buffer_first_char_wen` pulses, and the state returns to IDLE.
    - The offset updates only after the new line is blank, so garbage is never displayed.
  - **Any other byte:** consumed and ignored, with no state change.
- **Cursor column on LF:** `cursor_x` is unchanged by LF.

## Timing
- **Reset values:**
  - `cursor_x` = 0, `cursor_y` = 0, `line_start` = 0.
  - `buffer_first_char` = 0, `buffer_first_char_wen` = 0.
  - `buffer_waddr` = 0, `buffer_din` = 0, `buffer_wen` = 0.
  - `char_ready` = 0, state = CLEAR_ALL.
- **Edge numbering:** edges are counted from the first rising edge after `reset` deasserts, numbered 1, 2, ...
- **Power-on clear:** after edge k (k = 1..1920), `buffer_wen` = 1 and `buffer_waddr` = k-1. `char_ready` = 1 after edge 1920, and `buffer_wen` = 0 after edge 1921 unless a byte was accepted.
- **Printable byte:** accepted at edge E. After E, `buffer_wen`/`buffer_waddr`/`buffer_din` show the write and `cursor_x` shows the new column, with latency 1. With no accept at edge E+1, `buffer_wen` = 0 after E+1.
- **Scroll LF:** accepted at edge E.
  - `char_ready` = 0 after E.
  - Clear writes are visible after E+1..E+COLS.
  - After E+COLS: `buffer_first_char_wen` = 1 for exactly one cycle, the new `buffer_first_char` is valid, and `char_ready` = 1.
- **Busy periods:** while `char_ready` = 0, `char_valid` is ignored. The sender holds the byte until it is accepted.
- **Reset mid-operation:** reset asserted during CLEAR_LINE or CLEAR_ALL aborts the sequence immediately, with asynchronous return to the reset values. The full clear restarts on release.

## Test plan
- **Reset release:** observe 1920 consecutive writes of 0x20 at addresses 0..1919, then `char_ready` rises after edge 1920; cursor is (0,0) and `buffer_first_char` = 0.
- **Printable stream:** send "AB" back-to-back with `char_valid` held high → writes 0x41@0, then 0x42@1 on consecutive cycles, `cursor_x` = 2.
- **Column saturation:** 82 printable bytes on row 0 → `cursor_x` stays 79; bytes 80..82 all write addr 79.
- **CR/LF/BS:** with cursor (5,2), send BS, CR, LF → `cursor_x` 4 then 0, `cursor_y` 3. Then 'X' writes at addr 240; BS at x = 0 leaves x = 0.
- **Scroll:** 23 LFs then one more LF → 80 writes of 0x20 at 1920-wrapped addresses 0..79, then a single `buffer_first_char_wen` with value 80. `cursor_y` = 23, and the next 'Z' at x = 0 writes addr 0.
- **Scroll wrap and reset mid-clear:**
  - After 24 scrolls, `buffer_first_char` wraps 1840 → 0.
  - Asserting reset at clear write 40 clears all outputs to their reset values asynchronously, then the full 1920-write clear restarts.

Source files
------------

// File: rtl/char_buffer_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : char_buffer_writer_if
// Description : Byte-stream input and character-buffer/cursor output bundle
//               of the character buffer writer.
// Revision    : 1.0 - initial release
// ============================================================================
interface char_buffer_writer_if #(
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11
);
  logic [7:0]           char_in;
  logic                 char_valid;
  logic                 char_ready;
  logic [COL_BITS-1:0]  cursor_x;
  logic [ROW_BITS-1:0]  cursor_y;
  logic [ADDR_BITS-1:0] buffer_first_char;
  logic                 buffer_first_char_wen;
  logic [ADDR_BITS-1:0] buffer_waddr;
  logic [7:0]           buffer_din;
  logic                 buffer_wen;

  // master: the writer block; slave: byte source and video generator side
  modport master (
    input  char_in, char_valid,
    output char_ready, cursor_x, cursor_y, buffer_first_char,
           buffer_first_char_wen, buffer_waddr, buffer_din, buffer_wen
  );

  modport slave (
    output char_in, char_valid,
    input  char_ready, cursor_x, cursor_y, buffer_first_char,
           buffer_first_char_wen, buffer_waddr, buffer_din, buffer_wen
  );
endinterface
`default_nettype wire

// File: rtl/char_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : char_buffer_writer
// Description : Turns an ASCII byte stream into character-buffer writes,
//               cursor updates and scroll-offset updates; clears the screen.
// Revision    : 1.0 - initial release
// ============================================================================
module char_buffer_writer #(
  parameter int ROWS          = 24,
  parameter int COLS          = 80,
  parameter int ROW_BITS      = 5,
  parameter int COL_BITS      = 7,
  parameter int ADDR_BITS     = 11,
  parameter int PAST_LAST_ROW = ROWS * COLS
) (
  input  wire logic             clk,
  input  wire logic             reset,
  char_buffer_writer_if.master  bus
);

  localparam logic [1:0] S_CLEAR_ALL  = 2'd0;
  localparam logic [1:0] S_IDLE       = 2'd1;
  localparam logic [1:0] S_CLEAR_LINE = 2'd2;

  localparam logic [7:0] c_space = 8'h20;
  localparam logic [7:0] c_tilde = 8'h7E;
  localparam logic [7:0] c_cr    = 8'h0D;
  localparam logic [7:0] c_lf    = 8'h0A;
  localparam logic [7:0] c_bs    = 8'h08;

  localparam logic [ADDR_BITS-1:0] c_last_addr    = ADDR_BITS'(PAST_LAST_ROW - 1);
  localparam logic [ADDR_BITS-1:0] c_last_col_cnt = ADDR_BITS'(COLS - 1);
  localparam logic [COL_BITS-1:0]  c_last_col     = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0]  c_last_row     = ROW_BITS'(ROWS - 1);
  localparam logic [ADDR_BITS:0]   c_cols_ext     = (ADDR_BITS + 1)'(COLS);
  localparam logic [ADDR_BITS:0]   c_past_ext     = (ADDR_BITS + 1)'(PAST_LAST_ROW);

  // Row-granular advance with wrap at the end of the buffer
  function automatic logic [ADDR_BITS-1:0] f_row_advance(input logic [ADDR_BITS-1:0] a);
    logic [ADDR_BITS:0] sum;
    sum = {1'b0, a} + c_cols_ext;
    return (sum == c_past_ext) ? '0 : sum[ADDR_BITS-1:0];
  endfunction

  logic [1:0]           r_state;
  logic [ADDR_BITS-1:0] r_cnt;
  logic [ADDR_BITS-1:0] r_line_start;
  logic [COL_BITS-1:0]  r_cursor_x;
  logic [ROW_BITS-1:0]  r_cursor_y;
  logic [ADDR_BITS-1:0] r_first_char;
  logic                 r_first_char_wen;
  logic [ADDR_BITS-1:0] r_waddr;
  logic [7:0]           r_din;
  logic                 r_wen;
  logic                 r_ready;

  logic [1:0]           w_state_next;
  logic [ADDR_BITS-1:0] w_cnt_next;
  logic [ADDR_BITS-1:0] w_line_start_next;
  logic [COL_BITS-1:0]  w_cursor_x_next;
  logic [ROW_BITS-1:0]  w_cursor_y_next;
  logic [ADDR_BITS-1:0] w_first_char_next;
  logic                 w_first_char_wen_next;
  logic [ADDR_BITS-1:0] w_waddr_next;
  logic [7:0]           w_din_next;
  logic                 w_wen_next;

  logic w_accept;
  logic w_printable;
  logic w_scroll;

  assign w_accept    = (r_state == S_IDLE) && bus.char_valid;
  assign w_printable = (bus.char_in >= c_space) && (bus.char_in <= c_tilde);
  assign w_scroll    = w_accept && (bus.char_in == c_lf) && (r_cursor_y == c_last_row);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_CLEAR_ALL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLEAR_ALL:  if (r_cnt == c_last_addr)    w_state_next = S_IDLE;
      S_IDLE:       if (w_scroll)                w_state_next = S_CLEAR_LINE;
      S_CLEAR_LINE: if (r_cnt == c_last_col_cnt) w_state_next = S_IDLE;
      default:                                   w_state_next = S_CLEAR_ALL;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    w_cnt_next            = r_cnt;
    w_line_start_next     = r_line_start;
    w_cursor_x_next       = r_cursor_x;
    w_cursor_y_next       = r_cursor_y;
    w_first_char_next     = r_first_char;
    w_first_char_wen_next = 1'b0;
    w_waddr_next          = r_waddr;
    w_din_next            = r_din;
    w_wen_next            = 1'b0;
    case (r_state)
      S_CLEAR_ALL: begin
        w_wen_next   = 1'b1;
        w_waddr_next = r_cnt;
        w_din_next   = c_space;
        w_cnt_next   = r_cnt + ADDR_BITS'(1);
      end
      S_CLEAR_LINE: begin
        w_wen_next   = 1'b1;
        w_waddr_next = r_line_start + r_cnt;
        w_din_next   = c_space;
        w_cnt_next   = r_cnt + ADDR_BITS'(1);
        // Offset moves only once the incoming line is entirely blank
        if (r_cnt == c_last_col_cnt) begin
          w_first_char_next     = f_row_advance(r_first_char);
          w_first_char_wen_next = 1'b1;
        end
      end
      S_IDLE: begin
        if (w_accept) begin
          if (w_printable) begin
            w_wen_next   = 1'b1;
            w_waddr_next = r_line_start + ADDR_BITS'(r_cursor_x);
            w_din_next   = bus.char_in;
            if (r_cursor_x != c_last_col) w_cursor_x_next = r_cursor_x + COL_BITS'(1);
          end else begin
            case (bus.char_in)
              c_cr: w_cursor_x_next = '0;
              c_bs: if (r_cursor_x != '0) w_cursor_x_next = r_cursor_x - COL_BITS'(1);
              c_lf: begin
                w_line_start_next = f_row_advance(r_line_start);
                if (r_cursor_y != c_last_row) w_cursor_y_next = r_cursor_y + ROW_BITS'(1);
                else                          w_cnt_next      = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt            <= '0;
      r_line_start     <= '0;
      r_cursor_x       <= '0;
      r_cursor_y       <= '0;
      r_first_char     <= '0;
      r_first_char_wen <= 1'b0;
      r_waddr          <= '0;
      r_din            <= '0;
      r_wen            <= 1'b0;
      r_ready          <= 1'b0;
    end else begin
      r_cnt            <= w_cnt_next;
      r_line_start     <= w_line_start_next;
      r_cursor_x       <= w_cursor_x_next;
      r_cursor_y       <= w_cursor_y_next;
      r_first_char     <= w_first_char_next;
      r_first_char_wen <= w_first_char_wen_next;
      r_waddr          <= w_waddr_next;
      r_din            <= w_din_next;
      r_wen            <= w_wen_next;
      r_ready          <= (w_state_next == S_IDLE);
    end
  end

  assign bus.char_ready            = r_ready;
  assign bus.cursor_x              = r_cursor_x;
  assign bus.cursor_y              = r_cursor_y;
  assign bus.buffer_first_char     = r_first_char;
  assign bus.buffer_first_char_wen = r_first_char_wen;
  assign bus.buffer_waddr          = r_waddr;
  assign bus.buffer_din            = r_din;
  assign bus.buffer_wen            = r_wen;

endmodule
`default_nettype wire

// File: tb/tb_char_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_char_buffer_writer
// Description : Directed vector bench for the character buffer writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_char_buffer_writer;
  localparam int ROWS = 24;
  localparam int COLS = 80;
  localparam int PAST = ROWS * COLS;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  char_buffer_writer_if #(.ROW_BITS(5), .COL_BITS(7), .ADDR_BITS(11)) bus ();

  char_buffer_writer #(
    .ROWS(ROWS), .COLS(COLS), .ROW_BITS(5), .COL_BITS(7), .ADDR_BITS(11), .PAST_LAST_ROW(PAST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] ch;
    bit         wen;
    int         addr;
    logic [7:0] din;
    int         x;
    int         y;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(input logic [7:0] ch, input bit wen, input int addr, input int x, input int y);
    vec_t v;
    v.ch = ch; v.wen = wen; v.addr = addr; v.din = ch; v.x = x; v.y = y;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ch);
    bus.char_in    = ch;
    bus.char_valid = 1'b1;
    tick();
    bus.char_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"},   int'(bus.char_ready), 0);
    chk({tag, "_x"},       int'(bus.cursor_x), 0);
    chk({tag, "_y"},       int'(bus.cursor_y), 0);
    chk({tag, "_fc"},      int'(bus.buffer_first_char), 0);
    chk({tag, "_fc_wen"},  int'(bus.buffer_first_char_wen), 0);
    chk({tag, "_waddr"},   int'(bus.buffer_waddr), 0);
    chk({tag, "_din"},     int'(bus.buffer_din), 0);
    chk({tag, "_wen"},     int'(bus.buffer_wen), 0);
  endtask

  // Reset has just been released; edge 1 is the next rising edge
  task automatic check_power_on_clear(input string tag);
    int bad_wen = 0, bad_addr = 0, bad_din = 0, bad_rdy = 0;
    for (int k = 1; k <= PAST; k++) begin
      tick();
      if (bus.buffer_wen !== 1'b1)       bad_wen++;
      if (int'(bus.buffer_waddr) != k-1) bad_addr++;
      if (bus.buffer_din !== 8'h20)      bad_din++;
      if (k < PAST && bus.char_ready !== 1'b0) bad_rdy++;
    end
    chk({tag, "_clear_wen_bad"},  bad_wen, 0);
    chk({tag, "_clear_addr_bad"}, bad_addr, 0);
    chk({tag, "_clear_din_bad"},  bad_din, 0);
    chk({tag, "_ready_early"},    bad_rdy, 0);
    chk({tag, "_ready_1920"},     int'(bus.char_ready), 1);
    chk({tag, "_x"},              int'(bus.cursor_x), 0);
    chk({tag, "_y"},              int'(bus.cursor_y), 0);
    chk({tag, "_fc"},             int'(bus.buffer_first_char), 0);
    tick();
    chk({tag, "_wen_1921"},       int'(bus.buffer_wen), 0);
  endtask

  task automatic scroll(input int s, input int exp_line, input int exp_fc);
    int cyc;
    send(8'h0A);
    chk($sformatf("scroll%0d_ready_low", s), int'(bus.char_ready), 0);
    chk($sformatf("scroll%0d_y", s), int'(bus.cursor_y), ROWS-1);
    tick();
    chk($sformatf("scroll%0d_first_addr", s), int'(bus.buffer_waddr), exp_line);
    chk($sformatf("scroll%0d_first_wen", s), int'(bus.buffer_wen), 1);
    cyc = 1;
    while (bus.char_ready !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk($sformatf("scroll%0d_len", s), cyc, COLS);
    chk($sformatf("scroll%0d_last_addr", s), int'(bus.buffer_waddr), exp_line + COLS - 1);
    chk($sformatf("scroll%0d_fc_wen", s), int'(bus.buffer_first_char_wen), 1);
    chk($sformatf("scroll%0d_fc", s), int'(bus.buffer_first_char), exp_fc);
    tick();
    chk($sformatf("scroll%0d_fc_wen_off", s), int'(bus.buffer_first_char_wen), 0);
  endtask

  initial begin
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;

    // Cursor starts at (0,0) after the power-on clear
    vecs.push_back(mk("A",   1, 0,   1, 0));
    vecs.push_back(mk("B",   1, 1,   2, 0));
    vecs.push_back(mk(8'h0D, 0, 0,   0, 0));
    vecs.push_back(mk(8'h0A, 0, 0,   0, 1));
    vecs.push_back(mk(8'h0A, 0, 0,   0, 2));
    vecs.push_back(mk("a",   1, 160, 1, 2));
    vecs.push_back(mk("b",   1, 161, 2, 2));
    vecs.push_back(mk("c",   1, 162, 3, 2));
    vecs.push_back(mk("d",   1, 163, 4, 2));
    vecs.push_back(mk("e",   1, 164, 5, 2));
    vecs.push_back(mk(8'h08, 0, 0,   4, 2));
    vecs.push_back(mk(8'h07, 0, 0,   4, 2));
    vecs.push_back(mk(8'h0D, 0, 0,   0, 2));
    vecs.push_back(mk(8'h0A, 0, 0,   0, 3));
    vecs.push_back(mk("X",   1, 240, 1, 3));
    vecs.push_back(mk(8'h08, 0, 0,   0, 3));
    vecs.push_back(mk(8'h08, 0, 0,   0, 3));
    vecs.push_back(mk(8'hFF, 0, 0,   0, 3));
    vecs.push_back(mk(8'h7E, 1, 240, 1, 3));
    vecs.push_back(mk(8'h1F, 0, 0,   1, 3));
    vecs.push_back(mk(8'h20, 1, 241, 2, 3));

    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b0;
    check_power_on_clear("por");

    // Back-to-back table: char_valid stays high across vectors
    for (int i = 0; i < vecs.size(); i++) begin
      bus.char_in    = vecs[i].ch;
      bus.char_valid = 1'b1;
      tick();
      chk($sformatf("v%0d_wen", i), int'(bus.buffer_wen), int'(vecs[i].wen));
      if (vecs[i].wen) begin
        chk($sformatf("v%0d_addr", i), int'(bus.buffer_waddr), vecs[i].addr);
        chk($sformatf("v%0d_din", i), int'(bus.buffer_din), int'(vecs[i].din));
      end
      chk($sformatf("v%0d_x", i), int'(bus.cursor_x), vecs[i].x);
      chk($sformatf("v%0d_y", i), int'(bus.cursor_y), vecs[i].y);
      chk($sformatf("v%0d_ready", i), int'(bus.char_ready), 1);
    end
    bus.char_valid = 1'b0;
    tick();
    chk("idle_wen_low", int'(bus.buffer_wen), 0);

    // Column saturation on row 3 (line_start 240)
    send(8'h0D);
    for (int i = 0; i < 82; i++) begin
      bus.char_in    = 8'h61 + 8'(i % 26);
      bus.char_valid = 1'b1;
      tick();
      chk($sformatf("sat%0d_addr", i), int'(bus.buffer_waddr), 240 + ((i < COLS-1) ? i : COLS-1));
    end
    bus.char_valid = 1'b0;
    chk("sat_x", int'(bus.cursor_x), COLS-1);
    chk("sat_last_din", int'(bus.buffer_din), 8'h61 + (81 % 26));

    // Down to the last row
    send(8'h0D);
    for (int i = 0; i < 20; i++) send(8'h0A);
    chk("bottom_y", int'(bus.cursor_y), ROWS-1);
    chk("bottom_x", int'(bus.cursor_x), 0);

    // First scroll with a byte held pending through the busy period
    begin
      int bad_wen = 0, bad_addr = 0, bad_din = 0, bad_fcw = 0, bad_rdy = 0;
      send(8'h0A);
      chk("s1_ready_low", int'(bus.char_ready), 0);
      bus.char_in    = "Z";
      bus.char_valid = 1'b1;
      for (int j = 1; j <= COLS; j++) begin
        tick();
        if (bus.buffer_wen !== 1'b1)       bad_wen++;
        if (int'(bus.buffer_waddr) != j-1) bad_addr++;
        if (bus.buffer_din !== 8'h20)      bad_din++;
        if (bus.buffer_first_char_wen !== (j == COLS)) bad_fcw++;
        if (bus.char_ready !== (j == COLS))            bad_rdy++;
      end
      chk("s1_clear_wen_bad", bad_wen, 0);
      chk("s1_clear_addr_bad", bad_addr, 0);
      chk("s1_clear_din_bad", bad_din, 0);
      chk("s1_fc_wen_bad", bad_fcw, 0);
      chk("s1_ready_bad", bad_rdy, 0);
      chk("s1_fc", int'(bus.buffer_first_char), 80);
      chk("s1_y", int'(bus.cursor_y), ROWS-1);
      tick();
      bus.char_valid = 1'b0;
      chk("s1_z_wen", int'(bus.buffer_wen), 1);
      chk("s1_z_addr", int'(bus.buffer_waddr), 0);
      chk("s1_z_din", int'(bus.buffer_din), 8'h5A);
      chk("s1_z_x", int'(bus.cursor_x), 1);
      chk("s1_fc_wen_off", int'(bus.buffer_first_char_wen), 0);
    end

    // Remaining scrolls up to the offset wrap
    send(8'h0D);
    for (int s = 2; s <= ROWS; s++) scroll(s, ((s-1) * COLS) % PAST, (s * COLS) % PAST);
    chk("fc_wrap", int'(bus.buffer_first_char), 0);

    // Reset in the middle of a line clear
    send(8'h0A);
    repeat (40) tick();
    chk("mid_clear_addr", int'(bus.buffer_waddr), 39);
    chk("mid_clear_wen", int'(bus.buffer_wen), 1);
    #1 reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    repeat (2) tick();
    reset = 1'b0;
    check_power_on_clear("rerun");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
